display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_display_scan_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Purpose: binary-to-BCD conversion (double dabble) feeding a 4-digit multiplexed 7-segment scan.
// Latency: digits update NUM_BITS cycles after an accepted load; an/seg register one cycle after index/digits.
// Backpressure: load is ignored (not queued) while busy is high; the scan free-runs regardless.
module display_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_BITS    = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] value,
  input  logic                load,
  input  logic                blank_lz,
  output logic                busy,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned ITER_W = $clog2(NUM_BITS + 1);
  localparam int unsigned SR_W   = NUM_BITS + 16;

  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [ITER_W-1:0]     ITER_LAST = ITER_W'(NUM_BITS - 1);
  localparam logic [NUM_BITS+13:0]  SAT_WIDE  = (NUM_BITS + 14)'(9999);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [3:0][3:0]     digits_q, digits_d;
  logic [CNT_W-1:0]    refresh_q, refresh_d;
  logic [1:0]          index_q, index_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  // FSM strobes
  logic capture_en;
  logic iter_en;
  logic last_iter;

  // Datapath helpers
  logic [NUM_BITS+13:0] value_wide;
  logic [NUM_BITS-1:0]  cap_val;
  logic [SR_W-1:0]      sr_adj;
  logic [SR_W-1:0]      sr_shift;
  logic                 blank_cur;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept a load in IDLE, leave CONV after the last iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (iter_q == ITER_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes
  always_comb begin
    busy       = 1'b0;
    capture_en = 1'b0;
    iter_en    = 1'b0;
    last_iter  = 1'b0;
    case (state_q)
      IDLE: capture_en = load;
      CONV: begin
        busy      = 1'b1;
        iter_en   = 1'b1;
        last_iter = (iter_q == ITER_LAST);
      end
      default: ;
    endcase
  end

  // Conversion datapath: saturating capture, add-3 adjust then shift, digits commit on the last shift
  always_comb begin
    value_wide = {14'b0, value};
    cap_val    = (value_wide > SAT_WIDE) ? SAT_WIDE[NUM_BITS-1:0] : value;

    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[NUM_BITS + 4*i +: 4] >= 4'd5) begin
        sr_adj[NUM_BITS + 4*i +: 4] = sr_q[NUM_BITS + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = sr_adj << 1;

    sr_d     = sr_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    if (capture_en) begin
      sr_d   = {16'b0, cap_val};
      iter_d = '0;
    end else if (iter_en) begin
      sr_d   = sr_shift;
      iter_d = iter_q + ITER_W'(1);
      if (last_iter) begin
        digits_d = sr_shift[SR_W-1 -: 16];
      end
    end
  end

  // Scan: free-running refresh divider, digit index, and registered an/seg from the same index
  always_comb begin
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      index_d   = index_q + 2'd1;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
      index_d   = index_q;
    end

    case (index_q)
      2'd3:    blank_cur = (digits_q[3] == 4'd0);
      2'd2:    blank_cur = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0);
      2'd1:    blank_cur = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0) && (digits_q[1] == 4'd0);
      default: blank_cur = 1'b0;
    endcase

    an_d  = ~(4'b0001 << index_q);
    seg_d = (blank_lz && blank_cur) ? 7'b1111111 : seg_pat(digits_q[index_q]);
  end

  // Datapath and scan registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q    <= '0;
      sr_q      <= '0;
      digits_q  <= '0;
      refresh_q <= '0;
      index_q   <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= 7'b1000000;
    end else begin
      iter_q    <= iter_d;
      sr_q      <= sr_d;
      digits_q  <= digits_d;
      refresh_q <= refresh_d;
      index_q   <= index_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_display_scan_controller.sv
// Purpose: scoreboard bench for display_scan_controller with REFRESH_DIV=4, NUM_BITS=14.
// Latency: expected scan entries and busy widths are queued by stimulus, popped by monitors.
// Backpressure: every wait is cycle-bounded; a global watchdog ends the run.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  logic [10:0] scan_q[$];
  int          busy_q[$];

  always #5 clk = ~clk;

  display_scan_controller #(
    .REFRESH_DIV(4),
    .NUM_BITS   (14)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .load    (load),
    .blank_lz(blank_lz),
    .busy    (busy),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Scan monitor: on every digit change pop an expected {an,seg}; also check hold length and conversion stability
  initial begin : scan_mon
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic [10:0] e;
    int          hold;
    bit          hold_vld;
    hold = 0;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold     = 0;
        hold_vld = 1'b0;
      end else if (an != prev_an) begin
        if (hold_vld) check("scan_hold", hold, 4);
        check("dp_off", dp, 1);
        if (scan_q.size() > 0) begin
          e = scan_q.pop_front();
          check("scan_an", an, e[10:7]);
          check("scan_seg", seg, e[6:0]);
        end
        hold     = 1;
        hold_vld = 1'b1;
      end else begin
        hold++;
        if (busy) check("seg_stable_in_conv", seg, prev_seg);
      end
      prev_an  = an;
      prev_seg = seg;
    end
  end

  // Busy monitor: measure each busy pulse and compare with the queued expected width
  initial begin : busy_mon
    int bw;
    int exp_w;
    bw = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bw = 0;
      end else if (busy) begin
        bw++;
      end else if (bw != 0) begin
        if (busy_q.size() > 0) begin
          exp_w = busy_q.pop_front();
          check("busy_width", bw, exp_w);
        end else begin
          check("busy_unexpected_pulse", bw, 0);
        end
        bw = 0;
      end
    end
  end

  task automatic do_load(input logic [13:0] v, input bit exp_pulse);
    check("busy_before_load", busy, 0);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_after_load", busy, 1);
    if (exp_pulse) busy_q.push_back(14);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", busy, 0);
  endtask

  // Expected segments for an = 1110, 1101, 1011, 0111 in that order
  task automatic expect_scan(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    int n;
    n = 0;
    while (an === 4'b0111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (an !== 4'b0111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== 4'b0111) begin
      check("scan_sync_timeout", an, 4'b0111);
    end else begin
      @(negedge clk);
      scan_q.push_back({4'b1110, s0});
      scan_q.push_back({4'b1101, s1});
      scan_q.push_back({4'b1011, s2});
      scan_q.push_back({4'b0111, s3});
      n = 0;
      while (scan_q.size() > 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("scan_drain", scan_q.size(), 0);
      scan_q.delete();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    rst_n = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_busy", busy, 0);
    check("rst_dp", dp, 1);
    rst_n = 1'b1;
    expect_scan(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // Blanking applied to zero without reconversion
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    expect_scan(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

    // Main conversion
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    do_load(14'd1234, 1'b1);
    wait_idle();
    expect_scan(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // Saturation boundary and large value
    do_load(14'd10000, 1'b1);
    wait_idle();
    expect_scan(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
    do_load(14'd0, 1'b1);
    wait_idle();
    do_load(14'd12000, 1'b1);
    wait_idle();
    expect_scan(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

    // Leading-zero blanking patterns
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    do_load(14'd7, 1'b1);
    wait_idle();
    expect_scan(7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
    do_load(14'd1005, 1'b1);
    wait_idle();
    expect_scan(7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001);
    do_load(14'd40, 1'b1);
    wait_idle();
    expect_scan(7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111);

    // Load while busy is ignored
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    do_load(14'd42, 1'b1);
    repeat (2) @(negedge clk);
    value = 14'd99;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_during_ignored_load", busy, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("busy_no_requeue", busy, 0);
    expect_scan(7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000);

    // Reset in the 7th busy cycle aborts the conversion
    do_load(14'd5678, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_an", an, 4'b1110);
    check("midrst_seg", seg, 7'b1000000);
    check("midrst_dp", dp, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_load(14'd5678, 1'b1);
    wait_idle();
    expect_scan(7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010);

    repeat (4) @(negedge clk);
    check("busy_queue_empty", busy_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
